// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC output path: FSM encoding and default widths.
package cordic_pkg;

  localparam int DEF_DATA_WID = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/twos_serial_cell.sv
// One-bit two's-complement to magnitude rule: copy up to and including the first 1,
// then invert the remaining bits when the operand is negative.
module twos_serial_cell (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic sign,
  input  logic in_bit,
  output logic out_bit
);

  logic seen_one_q;

  // The flag still holds the state from before this bit, so the first 1 is copied.
  assign out_bit = in_bit ^ (sign & seen_one_q);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      seen_one_q <= 1'b0;
    end else if (en) begin
      seen_one_q <= seen_one_q | in_bit;
    end
  end

endmodule

// File: rtl/twos_to_signmag_serial.sv
// Bit-serial two's-complement to sign-magnitude decoder, LSB first, one operand in flight.
module twos_to_signmag_serial
  import cordic_pkg::*;
#(
  parameter int DATA_WID_ = DEF_DATA_WID,
  parameter int CNT_WID_  = $clog2(DATA_WID_) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_WID_-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sign,
  output logic [DATA_WID_-1:0] out_mag,
  output logic                 out_ovf,
  output logic                 busy
);

  localparam logic [DATA_WID_-1:0] MOST_NEG = {1'b1, {(DATA_WID_-1){1'b0}}};
  localparam logic [CNT_WID_-1:0]  LAST_CNT = CNT_WID_'(DATA_WID_ - 1);

  state_e                 state_q;
  logic [DATA_WID_-1:0]   shift_q;
  logic [DATA_WID_-1:0]   res_q;
  logic [DATA_WID_-1:0]   res_d;
  logic [DATA_WID_-1:0]   out_mag_q;
  logic [CNT_WID_-1:0]    cnt_q;
  logic                   sign_q;
  logic                   out_sign_q;
  logic                   out_ovf_q;
  logic                   cell_clr;
  logic                   cell_en;
  logic                   out_bit;
  logic                   last_shift;

  assign cell_clr   = (state_q == ST_IDLE) && in_valid;
  assign cell_en    = (state_q == ST_SHIFT);
  assign res_d      = {out_bit, res_q[DATA_WID_-1:1]};
  assign last_shift = (cnt_q == LAST_CNT);

  twos_serial_cell u_cell (
    .clk     (clk),
    .rst     (rst),
    .clr     (cell_clr),
    .en      (cell_en),
    .sign    (sign_q),
    .in_bit  (shift_q[0]),
    .out_bit (out_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      res_q      <= '0;
      cnt_q      <= '0;
      sign_q     <= 1'b0;
      out_sign_q <= 1'b0;
      out_mag_q  <= '0;
      out_ovf_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            shift_q <= in_data;
            sign_q  <= in_data[DATA_WID_-1];
            cnt_q   <= '0;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          shift_q <= shift_q >> 1;
          res_q   <= res_d;
          cnt_q   <= cnt_q + 1'b1;
          // The final bit lands in the MSB on this edge, so publish the completed word directly.
          if (last_shift) begin
            out_mag_q  <= res_d;
            out_sign_q <= sign_q;
            out_ovf_q  <= sign_q && (res_d == MOST_NEG);
            state_q    <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out_sign  = out_sign_q;
  assign out_mag   = out_mag_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_twos_to_signmag_serial.sv
// Scoreboard bench for the serial two's-complement to sign-magnitude decoder.
module tb_twos_to_signmag_serial;

  localparam int W = 32;

  typedef struct packed {
    logic         sign;
    logic [W-1:0] mag;
    logic         ovf;
  } res_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_sign;
  logic [W-1:0] out_mag;
  logic         out_ovf;
  logic         busy;

  res_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  twos_to_signmag_serial #(.DATA_WID_(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_mag   (out_mag),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic res_t model(input logic [W-1:0] op);
    res_t r;
    r.sign = op[W-1];
    r.mag  = op[W-1] ? (~op + 32'd1) : op;
    r.ovf  = (op == 32'h8000_0000);
    return r;
  endfunction

  // Called at a negedge; returns at the negedge following the capture edge.
  task automatic send_op(input logic [W-1:0] op, output bit ok);
    ok       = 1'b0;
    in_data  = op;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (in_ready) ok = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (ok) sb.push_back(model(op));
  endtask

  task automatic wait_out(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h1234_5678;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_handshake: in_ready=%b out_valid=%b busy=%b, want 1 0 0", in_ready, out_valid, busy);
    end
    n_checks++;
    if (out_sign !== 1'b0 || out_mag !== '0 || out_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: sign=%b mag=%h ovf=%b, want 0 00000000 0", out_sign, out_mag, out_ovf);
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: in_ready=%b busy=%b, want 1 0", in_ready, busy);
    end
  endtask

  task automatic test_directed;
    logic [W-1:0] vec [6] = '{32'hFFFF_FFFB, 32'h0000_0007, 32'h0000_0000,
                              32'h8000_0000, 32'h8000_0001, 32'h7FFF_FFFF};
    bit   ok;
    bit   lat_ok;
    res_t exp;
    out_ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      send_op(vec[v], ok);
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL directed_accept: operand %h not accepted", vec[v]);
        continue;
      end
      if (v == 0) begin
        lat_ok = 1'b1;
        for (int k = 1; k < W; k++) begin
          in_data = $urandom;
          @(negedge clk);
          if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) lat_ok = 1'b0;
        end
        @(negedge clk);
        n_checks++;
        if (!lat_ok || out_valid !== 1'b1 || in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL latency: out_valid=%b in_ready=%b shift_phase_ok=%b, want valid 1 after edge %0d", out_valid, in_ready, lat_ok, W);
        end
        ok = out_valid;
      end else begin
        wait_out(ok);
      end
      exp = sb.pop_front();
      n_checks++;
      if (!ok || {out_sign, out_mag, out_ovf} !== exp) begin
        n_fail++;
        $display("FAIL directed_%h: got sign=%b mag=%h ovf=%b valid=%b, want sign=%b mag=%h ovf=%b",
                 vec[v], out_sign, out_mag, out_ovf, out_valid, exp.sign, exp.mag, exp.ovf);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    bit   ok;
    bit   stable;
    res_t exp;
    out_ready = 1'b0;
    send_op(32'hFFFF_FF00, ok);
    wait_out(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL bp_result: no out_valid within bound");
      return;
    end
    exp      = sb.pop_front();
    in_valid = 1'b1;
    stable   = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_data = $urandom;
      @(negedge clk);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {out_sign, out_mag, out_ovf} !== exp) stable = 1'b0;
    end
    n_checks++;
    if (!stable) begin
      n_fail++;
      $display("FAIL bp_stall: got sign=%b mag=%h ovf=%b valid=%b ready=%b, want sign=%b mag=%h ovf=%b held",
               out_sign, out_mag, out_ovf, out_valid, in_ready, exp.sign, exp.mag, exp.ovf);
    end
    in_data   = 32'h0000_0042;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_mag !== exp.mag || out_sign !== exp.sign) begin
      n_fail++;
      $display("FAIL bp_release: valid=%b in_ready=%b mag=%h, want 0 1 %h", out_valid, in_ready, out_mag, exp.mag);
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_held_valid: busy=%b in_ready=%b, want 1 0", busy, in_ready);
    end
    sb.push_back(model(32'h0000_0042));
    wait_out(ok);
    exp = sb.pop_front();
    n_checks++;
    if (!ok || {out_sign, out_mag, out_ovf} !== exp) begin
      n_fail++;
      $display("FAIL bp_next: got sign=%b mag=%h ovf=%b, want sign=%b mag=%h ovf=%b",
               out_sign, out_mag, out_ovf, exp.sign, exp.mag, exp.ovf);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort;
    bit   ok;
    bit   quiet;
    res_t exp;
    out_ready = 1'b1;
    in_data   = 32'hFFFF_0000;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_state: in_ready=%b out_valid=%b busy=%b, want 1 0 0", in_ready, out_valid, busy);
    end
    quiet = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (out_valid !== 1'b0) quiet = 1'b0;
    end
    n_checks++;
    if (!quiet) begin
      n_fail++;
      $display("FAIL abort_discard: out_valid=1 seen after aborted operand, want 0");
    end
    send_op(32'hFFFF_FFFF, ok);
    wait_out(ok);
    exp = sb.pop_front();
    n_checks++;
    if (!ok || {out_sign, out_mag, out_ovf} !== exp) begin
      n_fail++;
      $display("FAIL abort_next: got sign=%b mag=%h ovf=%b, want sign=%b mag=%h ovf=%b",
               out_sign, out_mag, out_ovf, exp.sign, exp.mag, exp.ovf);
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    int sent = 0;
    int recv = 0;
    fork
      begin
        bit           ok;
        logic [W-1:0] op;
        for (int i = 0; i < 1000; i++) begin
          case ($urandom_range(0, 9))
            0:       op = 32'h0000_0000;
            1:       op = 32'h8000_0000;
            2:       op = 32'hFFFF_FFFF;
            3:       op = 32'h8000_0001;
            default: op = $urandom;
          endcase
          send_op(op, ok);
          if (!ok) break;
          sent++;
        end
      end
      begin
        res_t exp;
        for (int cyc = 0; cyc < 60000 && recv < 1000; cyc++) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 2) != 0);
          if (out_valid && out_ready) begin
            recv++;
            n_checks++;
            if (sb.size() == 0) begin
              n_fail++;
              $display("FAIL rand_spurious: output mag=%h with no operand pending", out_mag);
            end else begin
              exp = sb.pop_front();
              if ({out_sign, out_mag, out_ovf} !== exp) begin
                n_fail++;
                $display("FAIL rand_%0d: got sign=%b mag=%h ovf=%b, want sign=%b mag=%h ovf=%b",
                         recv, out_sign, out_mag, out_ovf, exp.sign, exp.mag, exp.ovf);
              end
            end
          end
        end
      end
    join
    n_checks++;
    if (sent != 1000 || recv != 1000 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL rand_count: sent=%0d received=%0d pending=%0d, want 1000 1000 0", sent, recv, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
